// File: rtl/contador_sincrono_aleatorio.sv
// Free-running 4-bit counter that steps through the scrambled decimal sequence
// 0-3-7-1-9-4-8-2-6-5 and returns any unused code (10-15) to 0 on the next clock.
module contador_sincrono_aleatorio (
   input  logic       clk,
   input  logic       rst,
   output logic [3:0] count
);

   logic [3:0] count_q;
   logic [3:0] count_d;

   // Full 16-entry decode; every illegal code falls through to 0 so the counter self-recovers
   always_comb begin
      count_d = 4'd0;
      case (count_q)
         4'd0:    count_d = 4'd3;
         4'd3:    count_d = 4'd7;
         4'd7:    count_d = 4'd1;
         4'd1:    count_d = 4'd9;
         4'd9:    count_d = 4'd4;
         4'd4:    count_d = 4'd8;
         4'd8:    count_d = 4'd2;
         4'd2:    count_d = 4'd6;
         4'd6:    count_d = 4'd5;
         4'd5:    count_d = 4'd0;
         default: count_d = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= 4'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_contador_sincrono_aleatorio.sv
// Scoreboard bench for the scrambled decimal counter: the stimulus process queues
// expected values and a negedge monitor pops and compares them.
module tb_contador_sincrono_aleatorio;

   logic       clk;
   logic       rst;
   logic [3:0] count;

   typedef struct {
      logic [3:0] exp;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   num_checks = 0;
   int   num_errors = 0;
   logic [3:0] model;
   int   seq_order[10] = '{0, 3, 7, 1, 9, 4, 8, 2, 6, 5};

   contador_sincrono_aleatorio dut (
      .clk   (clk),
      .rst   (rst),
      .count (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Successor taken from the order of the digit list, not from a transition table
   function automatic logic [3:0] model_next(input logic [3:0] cur);
      logic [3:0] nxt;
      nxt = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (seq_order[i] == int'(cur)) nxt = 4'(seq_order[(i + 1) % 10]);
      end
      return nxt;
   endfunction

   task automatic push_exp(input logic [3:0] e, input string t);
      exp_t item;
      item.exp = e;
      item.tag = t;
      sb.push_back(item);
   endtask

   task automatic run_edge(input string t);
      @(posedge clk);
      if (rst) model = model_next(model);
      else     model = 4'd0;
      #1;
      push_exp(model, t);
   endtask

   // Monitor: compares at every falling edge for which an expectation is queued
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t item;
         item = sb.pop_front();
         num_checks++;
         if (count !== item.exp) begin
            num_errors++;
            $display("[TB] FAIL %s: count=%0d expected=%0d at %0t", item.tag, count, item.exp, $time);
         end
         if (item.exp <= 4'd9) begin
            num_checks++;
            if (!(count <= 4'd9)) begin
               num_errors++;
               $display("[TB] FAIL %s_range: count=%0d expected<=9 at %0t", item.tag, count, $time);
            end
         end
      end
   end

   initial begin
      int bound;
      model = 4'd0;
      rst   = 1'b1;
      #1 rst = 1'b0;
      push_exp(4'd0, "powerup");
      #11 rst = 1'b1;

      for (int i = 0; i < 10; i++) run_edge("seq_first");
      for (int i = 0; i < 10; i++) run_edge("seq_repeat");

      // Asynchronous reset in the cycle where the counter shows 9
      bound = 0;
      while (model_next(model) != 4'd9 && bound < 20) begin
         run_edge("to_nine");
         bound++;
      end
      @(posedge clk);
      model = model_next(model);
      #2 rst = 1'b0;
      model = 4'd0;
      push_exp(4'd0, "async_rst");
      run_edge("rst_hold");
      #2 rst = 1'b1;
      run_edge("after_async");

      // Reset asserted in the same time step as the edge that would leave 8
      bound = 0;
      while (model != 4'd8 && bound < 20) begin
         run_edge("to_eight");
         bound++;
      end
      @(posedge clk);
      rst   = 1'b0;
      model = 4'd0;
      #1 push_exp(4'd0, "rst_dominance");
      #2 rst = 1'b1;
      run_edge("after_dominance");

      for (int v = 10; v <= 15; v++) begin
         @(posedge clk);
         #1 force dut.count_q = 4'(v);
         #1 release dut.count_q;
         model = 4'(v);
         push_exp(model, "illegal_load");
         run_edge("illegal_recover");
         run_edge("illegal_restart");
      end

      // Long run with occasional one-cycle reset pulses
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         if (rst) model = model_next(model);
         else     model = 4'd0;
         #1;
         if (!rst) begin
            rst = 1'b1;
         end else if ($urandom_range(19) == 0) begin
            rst   = 1'b0;
            model = 4'd0;
         end
         push_exp(model, "long_run");
      end

      bound = 0;
      while (sb.size() > 0 && bound < 5) begin
         @(negedge clk);
         bound++;
      end
      #1;
      if (sb.size() > 0) begin
         num_checks++;
         num_errors++;
         $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
